// File: rtl/bcd_down_counter.sv
// Loadable multi-digit packed-BCD down-counter with terminal-zero detect,
// optional wrap from zero to all nines, and clamping of invalid load digits.
module bcd_down_counter #(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   count,
    output logic                  zero,
    output logic                  done,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic         done_q, done_d;
    logic         wrap_q, wrap_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] clamp_val;
    logic [W-1:0] dec_val;
    logic [W-1:0] nines_val;
    logic         clamp_hit;
    logic         borrow;

    // Per-digit clamp of the load value and single-cycle borrow ripple.
    always_comb begin
        clamp_val = '0;
        dec_val   = '0;
        nines_val = '0;
        clamp_hit = 1'b0;
        borrow    = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            nines_val[4*k +: 4] = 4'd9;
            if (load_val[4*k +: 4] > 4'd9) begin
                clamp_val[4*k +: 4] = 4'd9;
                clamp_hit           = 1'b1;
            end else begin
                clamp_val[4*k +: 4] = load_val[4*k +: 4];
            end
            if (!borrow) begin
                dec_val[4*k +: 4] = count_q[4*k +: 4];
            end else if (count_q[4*k +: 4] != 4'd0) begin
                dec_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
                borrow            = 1'b0;
            end else begin
                dec_val[4*k +: 4] = 4'd9;
            end
        end
    end

    // Next-state selection: load beats tick; pulses default low.
    always_comb begin
        count_d    = count_q;
        done_d     = 1'b0;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            count_d    = clamp_val;
            load_err_d = clamp_hit;
        end else if (en) begin
            if (count_q != '0) begin
                count_d = dec_val;
                done_d  = (dec_val == '0);
            end else if (WRAP) begin
                count_d = nines_val;
                wrap_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            done_q     <= done_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign zero     = (count_q == '0);
    assign done     = done_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: one hold-at-zero and one wrapping
// instance share stimulus; expected values are hand-computed constants.
module tb_bcd_down_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] load_val;
    logic        en;

    logic [15:0] count0, count1;
    logic        zero0, zero1, done0, done1, wrap0, wrap1, err0, err1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_down_counter #(.DIGITS(4), .WRAP(1'b0)) u_hold (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
        .count(count0), .zero(zero0), .done(done0), .wrap(wrap0), .load_err(err0)
    );

    bcd_down_counter #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
        .count(count1), .zero(zero1), .done(done1), .wrap(wrap1), .load_err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs, let one rising edge happen, sample 1 time unit later.
    task automatic step(input logic r, input logic l, input logic [15:0] lv, input logic e);
        reset    = r;
        load     = l;
        load_val = lv;
        en       = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; load_val = '0; en = 1'b0;
        #2;

        step(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("rst_count", 32'(count0), 32'h0000);
        chk("rst_zero",  32'(zero0), 32'd1);
        chk("rst_done",  32'(done0), 32'd0);
        chk("rst_wrap",  32'(wrap1), 32'd0);
        chk("rst_err",   32'(err0), 32'd0);
        chk("rst_count_w", 32'(count1), 32'h0000);

        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("idle_count", 32'(count0), 32'h0000);

        step(1'b0, 1'b1, 16'h0003, 1'b0);
        chk("ld3_count", 32'(count0), 32'h0003);
        chk("ld3_zero",  32'(zero0), 32'd0);
        chk("ld3_err",   32'(err0), 32'd0);

        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("dn2_count", 32'(count0), 32'h0002);
        chk("dn2_done",  32'(done0), 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("dn1_count", 32'(count0), 32'h0001);
        chk("dn1_done",  32'(done0), 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("dn0_count", 32'(count0), 32'h0000);
        chk("dn0_done",  32'(done0), 32'd1);
        chk("dn0_zero",  32'(zero0), 32'd1);

        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("hold0_count", 32'(count0), 32'h0000);
        chk("hold0_done",  32'(done0), 32'd0);
        chk("hold0_wrap",  32'(wrap0), 32'd0);
        chk("w_tick_count", 32'(count1), 32'h9999);
        chk("w_tick_wrap",  32'(wrap1), 32'd1);
        chk("w_tick_done",  32'(done1), 32'd0);

        step(1'b0, 1'b1, 16'h0000, 1'b0);
        chk("ld0_count_w", 32'(count1), 32'h0000);
        chk("ld0_done_w",  32'(done1), 32'd0);
        chk("ld0_wrap_w",  32'(wrap1), 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("wrap_count", 32'(count1), 32'h9999);
        chk("wrap_pulse", 32'(wrap1), 32'd1);
        chk("wrap_done",  32'(done1), 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("wrap_clear", 32'(wrap1), 32'd0);
        chk("wrap_hold",  32'(count1), 32'h9999);

        step(1'b0, 1'b1, 16'h1000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("b1000_count", 32'(count0), 32'h0999);
        chk("b1000_done",  32'(done0), 32'd0);
        step(1'b0, 1'b1, 16'h0100, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("b0100_count", 32'(count0), 32'h0099);
        chk("b0100_done",  32'(done0), 32'd0);

        step(1'b0, 1'b1, 16'h1A3F, 1'b0);
        chk("inv_count", 32'(count0), 32'h1939);
        chk("inv_err",   32'(err0), 32'd1);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("inv_err_clr", 32'(err0), 32'd0);
        chk("inv_hold",    32'(count0), 32'h1939);

        step(1'b0, 1'b1, 16'h0042, 1'b1);
        chk("ld_en_count", 32'(count0), 32'h0042);
        chk("ld_en_err",   32'(err0), 32'd0);

        step(1'b0, 1'b1, 16'h0005, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("mid_count", 32'(count0), 32'h0003);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("mrst_count", 32'(count0), 32'h0000);
        chk("mrst_done",  32'(done0), 32'd0);
        chk("mrst_zero",  32'(zero0), 32'd1);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("mrst_done2", 32'(done0), 32'd0);
        chk("mrst_hold",  32'(count0), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
